// File: rtl/program_loader_pkg.sv
// Shared types and defaults for the program loader (instruction-memory writer).
// PROGRAM_LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and its CKSUM state.
package program_loader_pkg;

  localparam int PL_INSTR_LEN  = 32;
  localparam int PL_IADDR_LEN  = 10;
  localparam logic [7:0] PROG_HDR_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_LO,
    ST_ADDR_HI,
    ST_CNT_LO,
    ST_CNT_HI,
    ST_DATA,
    ST_ERROR
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , ST_CKSUM
`endif
  } pl_state_e;

endpackage

// File: rtl/program_loader_instr_assembler.sv
// Byte-lane assembler: a lane counter steers each stream byte into its little-endian
// slot and flags the byte that completes an instruction word.
module instr_assembler #(
  parameter int INSTR_LEN   = 32,
  parameter int INSTR_BYTES = (INSTR_LEN + 7) / 8
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 clr_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 word_valid_o,
  output logic [INSTR_LEN-1:0] word_o
);

  localparam int SR_W = INSTR_BYTES * 8;
  localparam int CW   = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;

  logic [SR_W-1:0] lanes_q;
  logic [SR_W-1:0] lanes_d;
  logic [CW-1:0]   cnt_q;
  logic            last_lane;

  // Incoming byte overlays its lane so the completed word is visible in the same cycle.
  genvar gi;
  generate
    for (gi = 0; gi < INSTR_BYTES; gi++) begin : g_lane
      assign lanes_d[gi*8 +: 8] = (cnt_q == CW'(gi)) ? byte_i : lanes_q[gi*8 +: 8];
    end
  endgenerate

  assign last_lane    = (cnt_q == CW'(INSTR_BYTES - 1));
  assign word_valid_o = byte_valid_i & last_lane;
  assign word_o       = lanes_d[INSTR_LEN-1:0];

  always_ff @(posedge clk) begin
    if (srst) begin
      lanes_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (byte_valid_i) begin
      lanes_q <= lanes_d;
      cnt_q   <= last_lane ? '0 : cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/program_loader.sv
// Program loader: parses the 0xA5-headed program image and writes instruction words.
// Optional trailing checksum enabled by PROGRAM_LOADER_CHECKSUM_EN.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTR_LEN   = PL_INSTR_LEN,
  parameter int IADDR_LEN   = PL_IADDR_LEN,
  parameter int INSTR_BYTES = (INSTR_LEN + 7) / 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [7:0]           din,
  input  logic                 din_valid,
  output logic                 din_ready,
  output logic                 mem_wr_en,
  output logic [IADDR_LEN-1:0] mem_wr_addr,
  output logic [INSTR_LEN-1:0] mem_wr_data,
  output logic                 prog_loading,
  output logic                 prog_done,
  output logic                 err
);

  pl_state_e            state_q;
  logic [15:0]          start_q;
  logic [7:0]           cnt_lo_q;
  logic [15:0]          remaining_q;
  logic [IADDR_LEN-1:0] waddr_q;
  logic                 mem_wr_en_q;
  logic [IADDR_LEN-1:0] mem_wr_addr_q;
  logic [INSTR_LEN-1:0] mem_wr_data_q;
  logic                 prog_loading_q;
  logic                 prog_done_q;
  logic                 err_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]           xor_q;
`endif

  logic                 word_valid;
  logic [INSTR_LEN-1:0] word;
  logic [15:0]          addr_full;
  logic [15:0]          cnt_full;
  logic [16:0]          end_addr;
  logic                 addr_bad;
  logic                 range_bad;

  // No backpressure: ready everywhere except the reset cycle itself.
  assign din_ready = ~RST;

  assign addr_full = {din, start_q[7:0]};
  assign cnt_full  = {din, cnt_lo_q};
  assign end_addr  = {1'b0, start_q} + {1'b0, cnt_full};
  assign addr_bad  = (addr_full >> IADDR_LEN) != 16'd0;
  assign range_bad = end_addr > (17'd1 << IADDR_LEN);

  instr_assembler #(
    .INSTR_LEN   (INSTR_LEN),
    .INSTR_BYTES (INSTR_BYTES)
  ) u_asm (
    .clk          (CLK),
    .srst         (RST),
    .clr_i        (state_q != ST_DATA),
    .byte_valid_i (din_valid && (state_q == ST_DATA)),
    .byte_i       (din),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= ST_IDLE;
      start_q        <= '0;
      cnt_lo_q       <= '0;
      remaining_q    <= '0;
      waddr_q        <= '0;
      mem_wr_en_q    <= 1'b0;
      mem_wr_addr_q  <= '0;
      mem_wr_data_q  <= '0;
      prog_loading_q <= 1'b0;
      prog_done_q    <= 1'b0;
      err_q          <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      xor_q          <= '0;
`endif
    end else begin
      mem_wr_en_q <= 1'b0;
      prog_done_q <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (din_valid && state_q inside {ST_ADDR_LO, ST_ADDR_HI, ST_CNT_LO, ST_CNT_HI, ST_DATA})
        xor_q <= xor_q ^ din;
`endif
      if (din_valid) begin
        case (state_q)
          ST_IDLE: begin
            if (din == PROG_HDR_BYTE) begin
              state_q        <= ST_ADDR_LO;
              prog_loading_q <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              xor_q          <= '0;
`endif
            end
          end
          ST_ADDR_LO: begin
            start_q[7:0] <= din;
            state_q      <= ST_ADDR_HI;
          end
          ST_ADDR_HI: begin
            start_q[15:8] <= din;
            if (addr_bad) begin
              state_q        <= ST_ERROR;
              err_q          <= 1'b1;
              prog_loading_q <= 1'b0;
            end else begin
              state_q <= ST_CNT_LO;
            end
          end
          ST_CNT_LO: begin
            cnt_lo_q <= din;
            state_q  <= ST_CNT_HI;
          end
          ST_CNT_HI: begin
            remaining_q <= cnt_full;
            waddr_q     <= start_q[IADDR_LEN-1:0];
            if (range_bad) begin
              state_q        <= ST_ERROR;
              err_q          <= 1'b1;
              prog_loading_q <= 1'b0;
            end else if (cnt_full == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              state_q        <= ST_CKSUM;
`else
              state_q        <= ST_IDLE;
              prog_done_q    <= 1'b1;
              prog_loading_q <= 1'b0;
`endif
            end else begin
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            if (word_valid) begin
              mem_wr_en_q   <= 1'b1;
              mem_wr_addr_q <= waddr_q;
              mem_wr_data_q <= word;
              waddr_q       <= waddr_q + IADDR_LEN'(1);
              remaining_q   <= remaining_q - 16'd1;
              if (remaining_q == 16'd1) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                state_q        <= ST_CKSUM;
`else
                state_q        <= ST_IDLE;
                prog_done_q    <= 1'b1;
                prog_loading_q <= 1'b0;
`endif
              end
            end
          end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          ST_CKSUM: begin
            prog_loading_q <= 1'b0;
            if (din == xor_q) begin
              state_q     <= ST_IDLE;
              prog_done_q <= 1'b1;
            end else begin
              state_q <= ST_ERROR;
              err_q   <= 1'b1;
            end
          end
`endif
          default: ;  // ERROR swallows bytes until reset
        endcase
      end
    end
  end

  assign mem_wr_en    = mem_wr_en_q;
  assign mem_wr_addr  = mem_wr_addr_q;
  assign mem_wr_data  = mem_wr_data_q;
  assign prog_loading = prog_loading_q;
  assign prog_done    = prog_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; the checksum byte is sent only when
// PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;
  import program_loader_pkg::*;

  logic                    CLK = 1'b0;
  logic                    RST;
  logic [7:0]              din;
  logic                    din_valid;
  logic                    din_ready;
  logic                    mem_wr_en;
  logic [PL_IADDR_LEN-1:0] mem_wr_addr;
  logic [PL_INSTR_LEN-1:0] mem_wr_data;
  logic                    prog_loading;
  logic                    prog_done;
  logic                    err;

  int checks = 0;
  int errors = 0;

  logic [PL_IADDR_LEN-1:0] wr_addr_q[$];
  logic [PL_INSTR_LEN-1:0] wr_data_q[$];
  int done_cnt = 0;

  program_loader dut (
    .CLK          (CLK),
    .RST          (RST),
    .din          (din),
    .din_valid    (din_valid),
    .din_ready    (din_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .prog_loading (prog_loading),
    .prog_done    (prog_done),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (mem_wr_en) begin
      wr_addr_q.push_back(mem_wr_addr);
      wr_data_q.push_back(mem_wr_data);
    end
    if (prog_done) done_cnt++;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    din = b;
    din_valid = 1'b1;
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt = 0;
  endtask

  task automatic send_body(input logic [15:0] start, input logic [15:0] n,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [7:0] ck_mask);
    logic [7:0]  cs;
    logic [31:0] w;
    cs = 8'h00;
    send_byte(start[7:0]);  cs ^= start[7:0];
    send_byte(start[15:8]); cs ^= start[15:8];
    send_byte(n[7:0]);      cs ^= n[7:0];
    send_byte(n[15:8]);     cs ^= n[15:8];
    for (int i = 0; i < int'(n); i++) begin
      w = (i == 0) ? w0 : w1;
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8]);
        cs ^= w[8*k +: 8];
      end
    end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    send_byte(cs ^ ck_mask);
`else
    if (ck_mask != 8'h00) cs = cs ^ ck_mask;
`endif
  endtask

  task automatic send_load(input logic [15:0] start, input logic [15:0] n,
                           input logic [31:0] w0, input logic [31:0] w1,
                           input logic [7:0] ck_mask);
    send_byte(PROG_HDR_BYTE);
    send_body(start, n, w0, w1, ck_mask);
  endtask

  task automatic check_two(input string tag, input logic [9:0] a0);
    check_val({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'd2);
    if (wr_addr_q.size() == 2) begin
      check_val({tag, "_a0"}, 64'(wr_addr_q[0]), 64'(a0));
      check_val({tag, "_d0"}, 64'(wr_data_q[0]), 64'h12345678);
      check_val({tag, "_a1"}, 64'(wr_addr_q[1]), 64'(a0 + 10'd1));
      check_val({tag, "_d1"}, 64'(wr_data_q[1]), 64'hDEADBEEF);
    end
    check_val({tag, "_done"}, 64'(done_cnt), 64'd1);
    check_val({tag, "_err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    din = 8'h00;
    din_valid = 1'b0;
    repeat (2) @(negedge CLK);
    check_val("rst_ready", 64'(din_ready), 64'd0);
    check_val("rst_err", 64'(err), 64'd0);
    check_val("rst_loading", 64'(prog_loading), 64'd0);
    check_val("rst_done", 64'(prog_done), 64'd0);
    check_val("rst_wr_en", 64'(mem_wr_en), 64'd0);
    check_val("rst_wr_addr", 64'(mem_wr_addr), 64'd0);
    check_val("rst_wr_data", 64'(mem_wr_data), 64'd0);
    RST = 1'b0;
    @(negedge CLK);
    check_val("ready_after_rst", 64'(din_ready), 64'd1);

    // Basic load at 0x010 with two instructions
    clear_log();
    send_byte(PROG_HDR_BYTE);
    check_val("loading_rise", 64'(prog_loading), 64'd1);
    send_body(16'h0010, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h00);
    check_val("final_done_pulse", 64'(prog_done), 64'd1);
    check_val("final_loading_fall", 64'(prog_loading), 64'd0);
    idle(3);
    check_two("basic", 10'h010);

    // Garbage before the header is discarded
    clear_log();
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    check_val("garbage_nwr", 64'(wr_addr_q.size()), 64'd0);
    check_val("garbage_loading", 64'(prog_loading), 64'd0);
    send_load(16'h0010, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h00);
    idle(3);
    check_two("after_garbage", 10'h010);

    // Empty program
    clear_log();
    send_load(16'h0005, 16'd0, 32'h0, 32'h0, 8'h00);
    idle(3);
    check_val("n0_nwr", 64'(wr_addr_q.size()), 64'd0);
    check_val("n0_done", 64'(done_cnt), 64'd1);
    check_val("n0_err", 64'(err), 64'd0);

    // Load ending exactly at the top of memory is legal
    clear_log();
    send_load(16'h03FE, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h00);
    idle(3);
    check_two("top_fit", 10'h3FE);

    // Overflowing range -> sticky error
    clear_log();
    send_byte(PROG_HDR_BYTE);
    send_byte(8'hFF);
    send_byte(8'h03);
    send_byte(8'h02);
    send_byte(8'h00);
    check_val("ovf_err", 64'(err), 64'd1);
    check_val("ovf_loading", 64'(prog_loading), 64'd0);
    check_val("ovf_ready", 64'(din_ready), 64'd1);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    send_load(16'h0010, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h00);
    idle(3);
    check_val("ovf_nwr", 64'(wr_addr_q.size()), 64'd0);
    check_val("ovf_done", 64'(done_cnt), 64'd0);
    check_val("ovf_err_sticky", 64'(err), 64'd1);
    do_reset();
    check_val("ovf_err_cleared", 64'(err), 64'd0);

    // Address high bits beyond the memory -> error at ADDR_HI
    clear_log();
    send_byte(PROG_HDR_BYTE);
    send_byte(8'h00);
    send_byte(8'h04);
    check_val("addr_hi_err", 64'(err), 64'd1);
    do_reset();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Corrupted checksum: writes land, then error and no done
    clear_log();
    send_load(16'h0010, 16'd2, 32'h12345678, 32'hDEADBEEF, 8'h01);
    idle(3);
    check_val("badck_nwr", 64'(wr_addr_q.size()), 64'd2);
    check_val("badck_err", 64'(err), 64'd1);
    check_val("badck_done", 64'(done_cnt), 64'd0);
    do_reset();
`endif

    // Reset in the middle of an instruction drops the partial word
    clear_log();
    send_byte(PROG_HDR_BYTE);
    send_byte(8'h20);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    din_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    check_val("midrst_no_wr", 64'(mem_wr_en), 64'd0);
    check_val("midrst_nwr", 64'(wr_addr_q.size()), 64'd0);
    send_load(16'h0020, 16'd1, 32'hCAFEF00D, 32'h0, 8'h00);
    idle(3);
    check_val("midrst_reload_nwr", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() == 1) begin
      check_val("midrst_a0", 64'(wr_addr_q[0]), 64'h020);
      check_val("midrst_d0", 64'(wr_data_q[0]), 64'hCAFEF00D);
    end
    check_val("midrst_done", 64'(done_cnt), 64'd1);
    check_val("midrst_err", 64'(err), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Writer side of the CPU instruction memory in the sha256crypt unit. Accepts a byte-stream program image from the input path, assembles bytes into instruction words and writes them through the instruction BRAM's write-only port, which the fetch unit reads. While a load is in progress it holds the CPU off the memory and reports completion or error.

## Interface
- `INSTR_LEN`, default `` `INSTR_LEN `` (sha256.vh): instruction width in bits.
- `IADDR_LEN`, default `` `IADDR_LEN `` (sha256.vh): instruction address width.
- `INSTR_BYTES`, default `(INSTR_LEN+7)/8`: bytes per instruction in the stream.

Ports:
- `CLK`  in  1  clock.
- `RST`  in  1  reset; synchronous, active-high.
- `din`  in  8  stream byte.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  byte accepted when `din_valid & din_ready`.
- `mem_wr_en`  out  1  instruction memory write strobe.
- `mem_wr_addr`  out  IADDR_LEN  write address.
- `mem_wr_data`  out  INSTR_LEN  write data.
- `prog_loading`  out  1  load in progress; the CPU must not start threads.
- `prog_done`  out  1  one-cycle pulse on successful load.
- `err`  out  1  sticky error.

## Operation
- Stream format: `0xA5` header, start address (2 bytes, LE), instruction count N (2 bytes, LE), N × INSTR_BYTES data bytes (each instruction LE, upper pad bits of the last byte ignored), then the checksum byte if enabled.
- FSM states: IDLE, ADDR_LO, ADDR_HI, CNT_LO, CNT_HI, DATA, CKSUM, ERROR.
- IDLE: bytes other than `0xA5` are discarded silently. `0xA5` -> ADDR_LO.
- ADDR/CNT states: capture one byte each. Address bits above IADDR_LEN-1 must be 0, and start+N must be ≤ 2**IADDR_LEN. Violation -> ERROR.
- CNT_HI with N=0 -> CKSUM, or IDLE with `prog_done` when the checksum is disabled. No writes occur.
- DATA: a byte counter selects the byte lane. When the last byte of an instruction is accepted, the instruction is written at the current address. The address then increments and the instruction counter decrements. After the last instruction -> CKSUM, or IDLE when the checksum is disabled.
- ERROR: `err`=1. `din_ready`=1 and all bytes are discarded. Only RST leaves this state.
- `prog_loading`=1 in every state except IDLE and ERROR.
- Reset values: FSM=IDLE, `err`=0, `prog_loading`=0, `prog_done`=0, `mem_wr_en`=0, `mem_wr_addr`=0, `mem_wr_data`=0, `din_ready`=0 during the RST cycle.

## Timing
- `din_ready`=1 in every state after reset; no backpressure, one byte per cycle sustained.
- Last byte of an instruction accepted on cycle T: `mem_wr_en`=1 on T+1, with registered addr/data stable that cycle only.
- Final byte accepted on T (last data byte or checksum): `prog_done` pulses on T+1 and `prog_loading` falls on T+1. When the final byte is a data byte, this coincides with the final `mem_wr_en`.
- Header accepted on T: `prog_loading` rises on T+1.
- RST mid-load: any partial instruction is dropped, and no write is issued on the cycle after RST. Words already written stay in memory.

## Configuration
- `PROGRAM_LOADER_CHECKSUM_EN` defined:
  - CKSUM state is present.
  - Running XOR covers all bytes after the header (address, count, data).
  - The received byte must equal the XOR. Match -> `prog_done`. Mismatch -> ERROR.
  - Writes are not retracted; the host must reload.
- Undefined: no CKSUM state and no checksum byte in the stream. The XOR logic is not synthesized.

## Structure
- sha256.vh holds `INSTR_LEN`, `IADDR_LEN` and the new `PROG_HDR_BYTE` (8'hA5).
- One sub-module, `instr_assembler`: byte-lane shift register plus byte counter that emits a word-valid strobe. The FSM, counters and checksum stay in `program_loader`.

## Test plan
- Header, addr=0x0010, N=2, two instructions, correct checksum:
  - writes at 0x010 and 0x011 with the LE-assembled data;
  - `prog_done` pulses once;
  - `err`=0.
- Garbage bytes 0x00 and 0xFF before the header: no writes, no error. The subsequent load behaves identically to the previous case.
- N=0 with valid checksum: zero writes and a single `prog_done`.
- Start address near the top with start+N > 2**IADDR_LEN:
  - ERROR after CNT_HI and no writes;
  - `err` stays 1 through later valid streams until RST.
- Checksum byte XOR'd with 0x01 (macro on): all N writes occur, then `err`=1 and no `prog_done`.
- RST asserted after 3 data bytes of the first instruction, then a new valid stream: no write from the partial word, and the new load completes correctly.
